// File: rtl/valid_credit_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : valid_credit_mc_pkg
// Purpose  : Shared derivation functions and the forward-link beat type for
//            the multi-channel valid/credit link (valid_credit_mc).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package valid_credit_mc_pkg;

  // The link beat is a fixed-width container. It supports up to 16 channels
  // and payloads of up to 64 bits. Bits above the instance's CH_W/DATA_W are
  // always zero.
  localparam int LINK_CH_W   = 4;
  localparam int LINK_DATA_W = 64;

  typedef struct packed {
    logic                   valid;
    logic [LINK_CH_W-1:0]   ch;
    logic [LINK_DATA_W-1:0] data;
  } link_beat_t;

  // A round trip takes VALID_FFS + 1 cycles forward and CREDIT_FFS + 1 cycles
  // back. This is exactly the number of receiver entries needed so that a
  // single channel can stream without a bubble.
  function automatic int calc_depth(input int valid_ffs, input int credit_ffs);
    return valid_ffs + credit_ffs + 2;
  endfunction

  function automatic int calc_ctr_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int calc_ch_w(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin arbiter. It gives a one-hot grant to the first
//            requester found at or above the pointer, wrapping at N. When a
//            grant is taken and advance is set, the pointer moves one past
//            the winner.
// Ports    : clk     in  1  clock
//            reset   in  1  asynchronous active-high reset (pointer -> 0)
//            req     in  N  request vector
//            advance in  1  commit the current grant (pointer update enable)
//            grant   out N  one-hot grant, or zero when nothing requests
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N <= 2) ? 1 : $clog2(N);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    int idx;
    grant = '0;
    ptr_d = ptr_q;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if ((grant == '0) && req[idx]) begin
        grant[idx] = 1'b1;
        ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
    if (!advance) ptr_d = ptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/valid_credit_mc.sv
`default_nettype none
// ============================================================================
// Module   : valid_credit_mc
// Purpose  : Multi-channel valid/credit link. A round-robin arbiter picks one
//            channel per cycle that has credit. The chosen beat travels through
//            a shared VALID_FFS-stage pipeline into that channel's receiver
//            FIFO. Each pop sends a credit back through a CREDIT_FFS-stage
//            pipeline.
// Ports    : clk        in  1              clock
//            reset      in  1              asynchronous active-high reset
//            in_valid   in  NUM_CH         sender valid per channel
//            in_data    in  NUM_CH*DATA_W  sender payload per channel
//            in_ready   out NUM_CH         one-hot accept (grant)
//            out_valid  out NUM_CH         receiver FIFO non-empty
//            out_data   out NUM_CH*DATA_W  receiver FIFO heads
//            out_ready  in  NUM_CH         receiver pop enables
//            credit_ctr out NUM_CH*CTR_W   outstanding beats per channel
//            err        out 1              sticky protocol error
// Config   : define VALID_CREDIT_MC_ERR_EN to build error detection. Without
//            it, err is tied low. Overflow still drops the beat and a credit
//            underflow still saturates at 0.
// Revision : 1.0 - initial release
// ============================================================================
module valid_credit_mc
  import valid_credit_mc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 4,
  parameter int VALID_FFS  = 3,
  parameter int CREDIT_FFS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*calc_ctr_w(calc_depth(VALID_FFS, CREDIT_FFS))-1:0] credit_ctr,
  output logic                     err
);

  localparam int DEPTH = calc_depth(VALID_FFS, CREDIT_FFS);
  localparam int CTR_W = calc_ctr_w(DEPTH);
  localparam int CH_W  = calc_ch_w(NUM_CH);
  localparam int PTR_W = $clog2(DEPTH);

  logic [NUM_CH-1:0] eligible, grant, pop, credit_ret;
  link_beat_t        beat_in, beat_out;

  // Reset gates the requests so that in_ready stays low during reset, even
  // though grant is combinational.
  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (eligible & {NUM_CH{~reset}}),
    .advance (1'b1),          // in_ready == grant, so every grant is taken
    .grant   (grant)
  );

  assign in_ready = grant;

  always_comb begin
    beat_in = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) begin
        beat_in.valid              = 1'b1;
        beat_in.ch[CH_W-1:0]       = CH_W'(c);
        beat_in.data[DATA_W-1:0]   = in_data[c*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------- forward
  if (VALID_FFS > 0) begin : g_vpipe
    link_beat_t stage_q [VALID_FFS];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < VALID_FFS; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= beat_in;
        for (int i = 1; i < VALID_FFS; i++) stage_q[i] <= stage_q[i-1];
      end
    end
    assign beat_out = stage_q[VALID_FFS-1];
  end else begin : g_vpass
    assign beat_out = beat_in;
  end

  // ---------------------------------------------------------- credit return
  if (CREDIT_FFS > 0) begin : g_cpipe
    logic [NUM_CH-1:0] cstage_q [CREDIT_FFS];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < CREDIT_FFS; i++) cstage_q[i] <= '0;
      end else begin
        cstage_q[0] <= pop;
        for (int i = 1; i < CREDIT_FFS; i++) cstage_q[i] <= cstage_q[i-1];
      end
    end
    assign credit_ret = cstage_q[CREDIT_FFS-1];
  end else begin : g_cpass
    assign credit_ret = pop;
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef VALID_CREDIT_MC_ERR_EN
  logic [NUM_CH-1:0] wr_drop, ret_underflow;
`endif

  // ------------------------------------------------- per-channel FIFO/credit
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CTR_W-1:0]  cnt_q, cnt_d, cred_q, cred_d;
    logic              wr_en, full, wr_ok;

    assign wr_en = beat_out.valid && (beat_out.ch == LINK_CH_W'(c));
    assign full  = (cnt_q == CTR_W'(DEPTH));
    assign wr_ok = wr_en && !full;     // a beat arriving at a full FIFO is lost

    assign out_valid[c]                  = (cnt_q != '0);
    assign out_data[c*DATA_W +: DATA_W]  = mem_q[rd_q];
    assign pop[c]                        = out_valid[c] && out_ready[c];
    assign eligible[c]                   = in_valid[c] && (cred_q < CTR_W'(DEPTH));
    assign credit_ctr[c*CTR_W +: CTR_W]  = cred_q;

`ifdef VALID_CREDIT_MC_ERR_EN
    assign wr_drop[c]       = wr_en && full;
    assign ret_underflow[c] = credit_ret[c] && !grant[c] && (cred_q == '0);
`endif

    always_comb begin
      rd_d   = rd_q;
      wr_d   = wr_q;
      cnt_d  = cnt_q;
      cred_d = cred_q;
      if (wr_ok)  wr_d = ptr_inc(wr_q);
      if (pop[c]) rd_d = ptr_inc(rd_q);
      if (wr_ok && !pop[c])      cnt_d = cnt_q + CTR_W'(1);
      else if (!wr_ok && pop[c]) cnt_d = cnt_q - CTR_W'(1);
      // If a grant and a returned credit arrive together, they cancel out.
      // A credit returned at zero saturates.
      if (grant[c] && !credit_ret[c])                      cred_d = cred_q + CTR_W'(1);
      else if (credit_ret[c] && !grant[c] && cred_q != '0) cred_d = cred_q - CTR_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_q   <= '0;
        wr_q   <= '0;
        cnt_q  <= '0;
        cred_q <= '0;
      end else begin
        rd_q   <= rd_d;
        wr_q   <= wr_d;
        cnt_q  <= cnt_d;
        cred_q <= cred_d;
      end
    end

    // Storage needs no reset, because cnt_q marks which entries are valid.
    always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_q] <= beat_out.data[DATA_W-1:0];
    end
  end

`ifdef VALID_CREDIT_MC_ERR_EN
  logic err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           err_q <= 1'b0;
    else if (|wr_drop || |ret_underflow) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_valid_credit_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_valid_credit_mc
// Purpose  : Self-checking bench for valid_credit_mc. It runs the default
//            instance against a cycle-level behavioural model. Two extra
//            instances cover the minimum-depth and deep single-channel
//            configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_valid_credit_mc;

  logic        clk, reset;
  logic [3:0]  in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [11:0] credit_ctr;
  logic        err;

  valid_credit_mc u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .credit_ctr(credit_ctr), .err(err));

  // DEPTH = 2, two channels (only ch0 streams)
  logic [1:0]  p0_iv, p0_ir, p0_ov, p0_or;
  logic [15:0] p0_id, p0_od;
  logic [3:0]  p0_cc;
  logic        p0_err;
  valid_credit_mc #(.DATA_W(8), .NUM_CH(2), .VALID_FFS(0), .CREDIT_FFS(0)) u_p0 (
    .clk(clk), .reset(reset), .in_valid(p0_iv), .in_data(p0_id),
    .in_ready(p0_ir), .out_valid(p0_ov), .out_data(p0_od),
    .out_ready(p0_or), .credit_ctr(p0_cc), .err(p0_err));

  // DEPTH = 11, one channel
  logic        p1_iv, p1_ir, p1_ov, p1_or;
  logic [7:0]  p1_id, p1_od;
  logic [3:0]  p1_cc;
  logic        p1_err;
  valid_credit_mc #(.DATA_W(8), .NUM_CH(1), .VALID_FFS(4), .CREDIT_FFS(5)) u_p1 (
    .clk(clk), .reset(reset), .in_valid(p1_iv), .in_data(p1_id),
    .in_ready(p1_ir), .out_valid(p1_ov), .out_data(p1_od),
    .out_ready(p1_or), .credit_ctr(p1_cc), .err(p1_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // ------------------------------------------------------------------ model
  // Each beat is granted at cycle n and becomes visible at n+4. A pop at
  // cycle p shows up as a credit decrement at p+3.
  typedef struct { logic [7:0] d; int t; } mbeat_t;
  mbeat_t mq [4][$];
  int     rq [4][$];
  int     cred_m [4];
  int     ptr_m = 0;
  int     ncyc  = 0;

  always @(negedge clk) begin : model_chk
    logic [3:0]  elig, exp_ir, exp_ov;
    logic [11:0] exp_cc;
    int          g, idx;
    mbeat_t      nb;
    if (reset) begin
      for (int c = 0; c < 4; c++) begin
        mq[c].delete();
        rq[c].delete();
        cred_m[c] = 0;
      end
      ptr_m = 0;
      chk("m_rst_in_ready", in_ready, 0);
      chk("m_rst_out_valid", out_valid, 0);
      chk("m_rst_credit", credit_ctr, 0);
      chk("m_rst_err", err, 0);
    end else begin
      for (int c = 0; c < 4; c++)
        while (rq[c].size() > 0 && rq[c][0] <= ncyc) begin
          void'(rq[c].pop_front());
          if (cred_m[c] > 0) cred_m[c]--;
        end
      exp_ov = '0; exp_cc = '0; elig = '0;
      for (int c = 0; c < 4; c++) begin
        exp_ov[c]          = (mq[c].size() > 0) && (mq[c][0].t <= ncyc);
        exp_cc[c*3 +: 3]   = 3'(cred_m[c]);
        elig[c]            = in_valid[c] && (cred_m[c] < 7);
      end
      g = -1;
      for (int i = 0; i < 4; i++) begin
        idx = (ptr_m + i) % 4;
        if (g < 0 && elig[idx]) g = idx;
      end
      exp_ir = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("m_in_ready", in_ready, exp_ir);
      chk("m_out_valid", out_valid, exp_ov);
      chk("m_credit", credit_ctr, exp_cc);
      chk("m_err", err, 0);
      for (int c = 0; c < 4; c++)
        if (exp_ov[c]) chk("m_out_data", out_data[c*8 +: 8], mq[c][0].d);
      if (g >= 0) begin
        cred_m[g]++;
        nb.d = in_data[g*8 +: 8];
        nb.t = ncyc + 4;
        mq[g].push_back(nb);
        ptr_m = (g + 1) % 4;
      end
      for (int c = 0; c < 4; c++)
        if (exp_ov[c] && out_ready[c]) begin
          void'(mq[c].pop_front());
          rq[c].push_back(ncyc + 3);
        end
    end
    ncyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    int acc, c3late, seq, rx0, rx1, sq0, sq1;
    int cnt [4];
    reset = 1'b1;
    in_valid = '0; in_data = '0; out_ready = 4'b1111;
    p0_iv = '0; p0_id = '0; p0_or = 2'b11;
    p1_iv = 1'b0; p1_id = '0; p1_or = 1'b1;
    in_valid = 4'b1111;                      // reset must still hold in_ready low
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_credit", credit_ctr, 0);
    tick();
    in_valid = '0;
    reset = 1'b0;
    repeat (2) tick();

    // Single beat on ch1
    in_valid = 4'b0010; in_data[15:8] = 8'hA5;
    @(negedge clk); chk("sb_grant", in_ready, 4'b0010);              // t
    tick(); in_valid = '0;
    @(negedge clk); chk("sb_ctr_t1", credit_ctr[5:3], 1);           // t+1
    tick(); tick();
    @(negedge clk); chk("sb_ov_t3", out_valid[1], 0);               // t+3
    tick();
    @(negedge clk); chk("sb_ov_t4", out_valid[1], 1);               // t+4
    chk("sb_od_t4", out_data[15:8], 8'hA5);
    tick(); tick();
    @(negedge clk); chk("sb_ctr_t6", credit_ctr[5:3], 1);           // t+6
    tick();
    @(negedge clk); chk("sb_ctr_t7", credit_ctr[5:3], 0);           // t+7
    repeat (3) tick();

    // Saturation on ch0
    out_ready = 4'b1110; in_valid = 4'b0001; acc = 0;
    for (int i = 0; i < 20; i++) begin
      in_data[7:0] = 8'(i + 16);
      @(negedge clk); if (in_ready[0]) acc++;
      tick();
    end
    @(negedge clk);
    chk("sat_accepted", acc, 7);
    chk("sat_credit", credit_ctr[2:0], 7);
    chk("sat_ready", in_ready[0], 0);
    chk("sat_err", err, 0);
    in_valid = '0; out_ready = 4'b1111;
    repeat (15) tick();

    // Fairness across four streaming channels
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    in_valid = 4'b1111;
    for (int i = 0; i < 40; i++) begin
      in_data = $urandom;
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (in_ready[c]) cnt[c]++;
      tick();
    end
    chk("fair_c0", cnt[0], 10);
    chk("fair_c1", cnt[1], 10);
    chk("fair_c2", cnt[2], 10);
    chk("fair_c3", cnt[3], 10);
    in_valid = '0;
    repeat (15) tick();

    // Isolation: ch2 stalled, ch3 streaming
    out_ready = 4'b1011; in_valid = 4'b1100; acc = 0; c3late = 0;
    for (int i = 0; i < 40; i++) begin
      in_data = $urandom;
      @(negedge clk);
      if (in_ready[2]) acc++;
      if (i >= 25 && in_ready[3]) c3late++;
      tick();
    end
    chk("iso_c2_beats", acc, 7);
    chk("iso_c2_credit", credit_ctr[8:6], 7);
    chk("iso_c3_rate", c3late, 15);
    in_valid = '0; out_ready = 4'b1111;
    repeat (15) tick();

    // Reset with beats in flight
    in_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      in_data[7:0] = 8'(8'h50 + i);
      tick();
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rm_out_valid", out_valid, 0);
    chk("rm_in_ready", in_ready, 0);
    chk("rm_credit", credit_ctr, 0);
    chk("rm_err", err, 0);
    tick(); tick();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_data[7:0] = 8'(k);
      @(negedge clk); chk("rm_accept", in_ready[0], 1);
      tick();
    end
    in_valid = '0;
    seq = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid[0]) begin
        chk("rm_order", out_data[7:0], seq);
        seq++;
      end
      tick();
    end
    chk("rm_count", seq, 5);

    // Parameter sweep: full throughput at minimum and deep configurations
    p0_iv = 2'b01; p1_iv = 1'b1; sq0 = 0; sq1 = 0; rx0 = 0; rx1 = 0;
    for (int i = 0; i < 60; i++) begin
      p0_id[7:0] = 8'(sq0); p1_id = 8'(sq1);
      @(negedge clk);
      chk("p0_ready", p0_ir[0], 1);
      chk("p1_ready", p1_ir, 1);
      if (p0_ov[0]) begin chk("p0_order", p0_od[7:0], 8'(rx0)); rx0++; end
      if (p1_ov)    begin chk("p1_order", p1_od, 8'(rx1)); rx1++; end
      if (p0_ir[0]) sq0++;
      if (p1_ir)    sq1++;
      tick();
    end
    chk("p0_received", rx0, 59);
    chk("p1_received", rx1, 55);
    chk("p0_err", p0_err, 0);
    chk("p1_err", p1_err, 0);
    p0_iv = '0; p1_iv = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/valid_credit_mc.md
VALID_CREDIT_MC -- requirements
Module: valid_credit_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width per beat.
REQ-002 SHALL have parameter NUM_CH, default 4, number of independent channels (1..16).
REQ-003 SHALL have parameter VALID_FFS, default 3, forward link register stages (0 allowed).
REQ-004 SHALL have parameter CREDIT_FFS, default 2, credit-return register stages (0 allowed).
REQ-005 SHALL derive localparams DEPTH = VALID_FFS+CREDIT_FFS+2, CTR_W = $clog2(DEPTH+1), CH_W = max(1,$clog2(NUM_CH)).
REQ-006 SHALL have ports: clk  in  1  sole clock; reset  in  1  asynchronous active-high reset.
REQ-007 SHALL have ports: in_valid  in  NUM_CH  per-channel sender valid; in_data  in  NUM_CH*DATA_W  per-channel payload; in_ready  out  NUM_CH  per-channel accept.
REQ-008 SHALL have ports: out_valid  out  NUM_CH  per-channel receiver valid; out_data  out  NUM_CH*DATA_W  per-channel head payload; out_ready  in  NUM_CH  per-channel receiver ready.
REQ-009 SHALL have ports: credit_ctr  out  NUM_CH*CTR_W  per-channel outstanding count; err  out  1  sticky protocol error.

Function
REQ-010 Channel c SHALL be eligible when in_valid[c]=1 and credit_ctr[c] < DEPTH.
REQ-011 A round-robin arbiter SHALL grant at most one eligible channel per cycle, searching from rr_ptr upward with wrap; in_ready[c] SHALL equal grant[c] (one-hot or zero).
REQ-012 After a grant to channel g, rr_ptr SHALL become (g+1) mod NUM_CH; with no grant rr_ptr SHALL hold.
REQ-013 A granted beat SHALL enter a shared VALID_FFS-deep pipeline carrying {valid, ch id, data}; with VALID_FFS=0 the beat passes combinationally to the receiver write port.
REQ-014 The receiver SHALL hold one DEPTH-entry FIFO per channel; a pipeline-output beat SHALL be written into FIFO[ch id].
REQ-015 out_valid[c] SHALL be 1 exactly when FIFO[c] is non-empty; out_data[c] SHALL show its head; pop on out_valid[c]&out_ready[c].
REQ-016 Latency: beat accepted at cycle t SHALL raise out_valid at t+VALID_FFS+1 when its FIFO was empty; per-channel order SHALL be preserved.
REQ-017 Each pop SHALL launch credit bit c into a NUM_CH-wide CREDIT_FFS-deep pipeline; its output returns credits.
REQ-018 credit_ctr[c]: +1 on grant only, -1 on returned credit only, hold when both or neither; a pop at t SHALL be reflected in credit_ctr at t+CREDIT_FFS+1.
REQ-019 Returned credit with credit_ctr[c]=0 SHALL keep 0 and set err; write to a full FIFO SHALL drop the beat and set err.
REQ-020 Full throughput: a single channel with out_ready=1 SHALL sustain one beat per cycle indefinitely.
REQ-021 Channels SHALL be independent: a stalled channel (out_ready=0) SHALL never block grants to others.

Reset
REQ-022 While reset=1: credit_ctr=0, rr_ptr=0, all pipeline valids/credits=0, all FIFOs empty, out_valid=0, in_ready=0, err=0; pipeline data registers cleared to 0.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight beats and credits immediately; first grant possible the cycle after release.

Configuration
REQ-024 With VALID_CREDIT_MC_ERR_EN defined, err detection per REQ-019 SHALL be compiled in; without it err SHALL be tied 0 and no detection logic built (overflow/underflow behaviour still drop/saturate).

Structure
REQ-025 Package valid_credit_mc_pkg SHALL hold the DEPTH/CTR_W/CH_W derivation functions and the link beat struct typedef {valid, ch, data}.
REQ-026 Arbitration SHALL be a sub-module rr_arbiter (parameter N, inputs req and advance, output one-hot grant).

Verification
REQ-027 Single beat: ch1 in_data=0xA5 at t=10, defaults -> out_valid[1] at t=14, out_data[1]=0xA5; credit_ctr[1] 1 then 0 at t=17.
REQ-028 Saturation: ch0 out_ready=0, in_valid[0]=1 continuous -> exactly 7 beats accepted, credit_ctr[0]=7, in_ready[0]=0 thereafter, no err.
REQ-029 Fairness: all 4 channels valid continuously, out_ready=all 1 -> grants 0,1,2,3,0,... each channel 25% of beats.
REQ-030 Isolation: ch2 stalled (out_ready[2]=0) with ch3 streaming -> ch3 sustains 1 beat/cycle after ch2 saturates at 7.
REQ-031 Reset mid-flight: assert reset with 5 beats in flight -> all outputs 0 next edge; post-release traffic 0x01..0x04 on ch0 delivered in order.
REQ-032 Param sweep: VALID_FFS=0, CREDIT_FFS=0 (DEPTH=2) and VALID_FFS=4, CREDIT_FFS=5, NUM_CH=1 -> full throughput per REQ-020, err=0.
